axi_wr_ctrl_d: RTL and testbench

AXI_WR_CTRL_D -- requirements
Module: axi_wr_ctrl_d

---
 rtl/axi_wr_ctrl_d.sv | 152 +++++++++++++++
 tb/tb_axi_wr_ctrl_d.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_ctrl_d.sv
// ---------------------------------------------------------------------------
// axi_wr_ctrl_d
// Write-back controller that turns one D-cache victim line (cached) or one
// uncached store word into a single AXI write transaction: an AW beat, a
// burst of W beats, then the B response.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   wr_req/wr_rdy         : request handshake (accepted only while idle)
//   wr_addr, wr_data,
//   wr_uncache, wr_wstrb  : request payload, latched on acceptance
//   wr_done               : one-cycle pulse when the B response is taken
//   aw*, w*, b*           : AXI write address / data / response channels
// ---------------------------------------------------------------------------
module axi_wr_ctrl_d #(
    parameter int         LINE_WORDS = 16,
    parameter logic [1:0] BURST_TYPE = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    // request side
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    input  logic                     wr_uncache,
    input  logic [3:0]               wr_wstrb,
    output logic                     wr_rdy,
    output logic                     wr_done,
    // AW channel
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    // W channel
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    // B channel
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int         CW        = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [31:0]                   addr_q, addr_d;
    logic [LINE_WORDS-1:0][31:0]   data_q, data_d;
    logic [3:0]                    strb_q, strb_d;
    // last beat index of the burst: LAST_BEAT for a line, 0 for an uncached word
    logic [CW-1:0]                 len_q, len_d;
    logic [CW-1:0]                 cnt_q, cnt_d;

    logic                          bresp_unused;
    assign bresp_unused = ^bresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Channel payloads come straight from the latched request so they stay
    // stable for the whole stall window and read zero after reset.
    assign awaddr  = addr_q;
    assign awlen   = 8'(len_q);
    assign awsize  = 3'b010;
    assign awburst = BURST_TYPE;
    assign wdata   = data_q[cnt_q];
    assign wstrb   = strb_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_rdy  = 1'b0;
        wr_done = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;

        case (state_q)
            IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) begin
                    data_d  = wr_data;
                    cnt_d   = '0;
                    state_d = AW;
                    if (wr_uncache) begin
                        addr_d = wr_addr;
                        strb_d = wr_wstrb;
                        len_d  = '0;
                    end else begin
                        addr_d = {wr_addr[31:6], 6'b0};
                        strb_d = 4'hF;
                        len_d  = LAST_BEAT;
                    end
                end
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_d = W;
            end
            W: begin
                wvalid = 1'b1;
                wlast  = (cnt_q == len_q);
                if (wready) begin
                    // hold the counter on the final beat so it never wraps
                    if (wlast) state_d = B;
                    else       cnt_d   = cnt_q + 1'b1;
                end
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wr_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_ctrl_d.sv
module tb_axi_wr_ctrl_d;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_uncache;
    logic [3:0]   wr_wstrb;
    logic         wr_rdy, wr_done;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    int checks   = 0;
    int failures = 0;

    // observations gathered by run_burst
    logic [31:0] obs_awaddr;
    logic [7:0]  obs_awlen;
    logic [2:0]  obs_awsize;
    logic [1:0]  obs_awburst;
    int          aw_changes, aw_hs, overlap, bready_cycles, done_cnt, done_cyc, last_cyc;
    logic        rdy_after;
    bit          timed_out;
    logic [31:0] bdata[$];
    logic [3:0]  bstrb[$];
    logic        blast[$];

    axi_wr_ctrl_d #(.LINE_WORDS(16), .BURST_TYPE(2'b01)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_uncache(wr_uncache), .wr_wstrb(wr_wstrb),
        .wr_rdy(wr_rdy), .wr_done(wr_done),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    // Drives one request and records what the channels do, cycle by cycle.
    // Cycle 1 is the acceptance cycle; inputs are scrambled afterwards.
    task automatic run_burst(input logic [31:0] addr, input logic [511:0] data,
                             input logic unc, input logic [3:0] strb,
                             input int aw_stall, input bit w_toggle,
                             input int b_delay, input bit req_in_w);
        bit   req_sent = 0;
        bit   prev_w   = 0;
        bit   first_aw = 1;
        int   done_at  = -1;
        bit   finished = 0;
        aw_changes = 0; aw_hs = 0; overlap = 0; bready_cycles = 0;
        done_cnt = 0; done_cyc = -1; last_cyc = 0; rdy_after = 1'b0; timed_out = 0;
        obs_awaddr = '0; obs_awlen = '0; obs_awsize = '0; obs_awburst = '0;
        bdata.delete(); bstrb.delete(); blast.delete();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == 1) begin
                wr_req = 1'b1; wr_addr = addr; wr_data = data;
                wr_uncache = unc; wr_wstrb = strb;
            end else begin
                wr_req = 1'b0;
                if (req_in_w && prev_w && !req_sent) begin
                    wr_req   = 1'b1;
                    req_sent = 1;
                end
                wr_addr = ~addr; wr_data = ~data; wr_uncache = ~unc; wr_wstrb = ~strb;
            end
            awready = (cyc >= 2 + aw_stall);
            wready  = w_toggle ? (cyc % 2 == 1) : 1'b1;
            bvalid  = (last_cyc > 0) && (cyc >= last_cyc + 1 + b_delay) && (done_at < 0);
            #1;
            if (done_at > 0 && cyc == done_at + 1) begin
                rdy_after = wr_rdy;
                finished  = 1;
                @(posedge clk); #1;
                break;
            end
            if (awvalid) begin
                if (first_aw) begin
                    obs_awaddr = awaddr; obs_awlen = awlen;
                    obs_awsize = awsize; obs_awburst = awburst;
                    first_aw = 0;
                end else if (awaddr !== obs_awaddr || awlen !== obs_awlen) begin
                    aw_changes++;
                end
                if (awready) aw_hs++;
            end
            if ((int'(awvalid) + int'(wvalid) + int'(bready)) > 1) overlap++;
            if (wvalid && aw_hs == 0) overlap++;
            if (wvalid && wready) begin
                bdata.push_back(wdata); bstrb.push_back(wstrb); blast.push_back(wlast);
                if (wlast) last_cyc = cyc;
            end
            if (bready) bready_cycles++;
            if (wr_done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = cyc; done_cyc = cyc; end
            end
            prev_w = wvalid;
            @(posedge clk); #1;
        end
        wr_req = 1'b0; bvalid = 1'b0;
        if (!finished) timed_out = 1;
    endtask

    task automatic check_beats(input string name, input logic [511:0] data, input int n);
        checks++;
        if (bdata.size() !== n) begin
            failures++;
            $display("FAIL %s beat_count got=%0d exp=%0d", name, bdata.size(), n);
        end
        for (int i = 0; i < bdata.size() && i < n; i++) begin
            checks++;
            if (bdata[i] !== data[32*i +: 32] || blast[i] !== (i == n - 1)) begin
                failures++;
                $display("FAIL %s beat%0d got=%h/last%b exp=%h/last%b", name, i,
                         bdata[i], blast[i], data[32*i +: 32], (i == n - 1));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_uncache = 1'b0;
        wr_wstrb = '0; awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({wr_rdy, wr_done, awvalid, wvalid, wlast, bready} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {wr_rdy, wr_done, awvalid, wvalid, wlast, bready});
        end
        checks++;
        if (awaddr !== 32'h0 || awlen !== 8'h0 || wdata !== 32'h0 || wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0/0/0/0", awaddr, awlen, wdata, wstrb);
        end
    endtask

    task automatic test_cached;
        logic [511:0] line = make_line(32'h1000);
        run_burst(32'h1C00_0074, line, 1'b0, 4'h5, 0, 0, 0, 0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL cached_timeout got=timeout exp=done"); end
        checks++;
        if (obs_awaddr !== 32'h1C00_0040 || obs_awlen !== 8'd15 ||
            obs_awsize !== 3'b010 || obs_awburst !== 2'b01) begin
            failures++;
            $display("FAIL cached_aw got=%h/%0d/%b/%b exp=1c000040/15/010/01",
                     obs_awaddr, obs_awlen, obs_awsize, obs_awburst);
        end
        check_beats("cached", line, 16);
        checks++;
        if (bstrb.size() > 0 && bstrb[0] !== 4'hF) begin
            failures++; $display("FAIL cached_wstrb got=%h exp=f", bstrb[0]);
        end
        checks++;
        if (done_cyc !== 19 || done_cnt !== 1) begin
            failures++; $display("FAIL cached_done got=cyc%0d/n%0d exp=cyc19/n1", done_cyc, done_cnt);
        end
        checks++;
        if (rdy_after !== 1'b1 || overlap !== 0) begin
            failures++; $display("FAIL cached_rdy_overlap got=%b/%0d exp=1/0", rdy_after, overlap);
        end
    endtask

    task automatic test_uncached;
        logic [511:0] d = make_line(32'h5555_0000);
        d[31:0] = 32'hDEAD_BEEF;
        run_burst(32'hBFD0_0004, d, 1'b1, 4'b0011, 0, 0, 0, 0);
        checks++;
        if (obs_awaddr !== 32'hBFD0_0004 || obs_awlen !== 8'd0) begin
            failures++; $display("FAIL unc_aw got=%h/%0d exp=bfd00004/0", obs_awaddr, obs_awlen);
        end
        checks++;
        if (bdata.size() !== 1 || bdata[0] !== 32'hDEAD_BEEF || bstrb[0] !== 4'b0011 || blast[0] !== 1'b1) begin
            failures++;
            $display("FAIL unc_beat got=n%0d/%h/%b/%b exp=n1/deadbeef/0011/1", bdata.size(),
                     (bdata.size() > 0) ? bdata[0] : 32'h0, (bstrb.size() > 0) ? bstrb[0] : 4'h0,
                     (blast.size() > 0) ? blast[0] : 1'b0);
        end
        checks++;
        if (done_cyc !== 4 || done_cnt !== 1 || rdy_after !== 1'b1) begin
            failures++;
            $display("FAIL unc_done got=cyc%0d/n%0d/rdy%b exp=cyc4/n1/rdy1", done_cyc, done_cnt, rdy_after);
        end
    endtask

    task automatic test_backpressure;
        logic [511:0] line = make_line(32'hA000_0000);
        run_burst(32'h0000_1238, line, 1'b0, 4'h0, 3, 1, 0, 0);
        checks++;
        if (obs_awaddr !== 32'h0000_1200 || aw_changes !== 0 || aw_hs !== 1) begin
            failures++;
            $display("FAIL bp_aw got=%h/chg%0d/hs%0d exp=00001200/chg0/hs1", obs_awaddr, aw_changes, aw_hs);
        end
        check_beats("bp", line, 16);
        checks++;
        if (done_cnt !== 1 || overlap !== 0 || timed_out) begin
            failures++; $display("FAIL bp_done got=n%0d/ov%0d/to%0d exp=n1/ov0/to0", done_cnt, overlap, timed_out);
        end
    endtask

    task automatic test_delayed_b;
        logic [511:0] line = make_line(32'h0BAD_0000);
        run_burst(32'h2000_0000, line, 1'b0, 4'h0, 0, 0, 4, 0);
        checks++;
        if (bready_cycles !== 5 || done_cnt !== 1 || done_cyc !== 23) begin
            failures++;
            $display("FAIL delb_b got=br%0d/n%0d/cyc%0d exp=br5/n1/cyc23", bready_cycles, done_cnt, done_cyc);
        end
        checks++;
        if (rdy_after !== 1'b1) begin
            failures++; $display("FAIL delb_rdy got=%b exp=1", rdy_after);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [511:0] line = make_line(32'h7700_0000);
        logic [511:0] line2 = make_line(32'h8800_0000);
        int beats = 0;
        int stray = 0;
        bit reached = 0;
        wr_req = 1'b1; wr_addr = 32'h3000_0000; wr_data = line; wr_uncache = 1'b0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            #1;
            if (wvalid && wready) beats++;
            @(posedge clk); #1;
            wr_req = 1'b0;
            if (beats == 7) begin reached = 1; break; end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!reached || wdata !== 32'h7700_0007) begin
            failures++; $display("FAIL rstmid_beat7 got=%h exp=77000007", wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (wvalid !== 1'b0 || wr_rdy !== 1'b1 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after got=wv%b/rdy%b/done%b exp=wv0/rdy1/done0", wvalid, wr_rdy, wr_done);
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wvalid || awvalid || wr_done) stray++;
            @(posedge clk); #1;
        end
        checks++;
        if (stray !== 0) begin
            failures++; $display("FAIL rstmid_stray got=%0d exp=0", stray);
        end
        bvalid = 1'b0;
        run_burst(32'h3000_0040, line2, 1'b0, 4'h0, 0, 0, 0, 0);
        check_beats("rstmid_new", line2, 16);
    endtask

    task automatic test_req_in_w;
        logic [511:0] line = make_line(32'h4400_0000);
        run_burst(32'h5000_0080, line, 1'b0, 4'h0, 0, 0, 0, 1);
        check_beats("reqw", line, 16);
        checks++;
        if (aw_hs !== 1 || done_cnt !== 1 || done_cyc !== 19) begin
            failures++;
            $display("FAIL reqw_txn got=hs%0d/n%0d/cyc%0d exp=hs1/n1/cyc19", aw_hs, done_cnt, done_cyc);
        end
        #1;
        checks++;
        if (awvalid !== 1'b0 || wr_rdy !== 1'b1) begin
            failures++; $display("FAIL reqw_queued got=aw%b/rdy%b exp=aw0/rdy1", awvalid, wr_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_cached();
        test_uncached();
        test_backpressure();
        test_delayed_b();
        test_reset_mid_burst();
        test_req_in_w();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
